// File: rtl/memshare_vnu_out.sv
// memshare_vnu_out -- output-side assembler for one IB-RAM column-bank share group.
//
// Shared columns read their bank one cycle after the non-shared columns, so every
// VNU message arrives as two bank beats: phase 0 carries the non-shared lanes and
// phase 1 the shared lanes. Phase 0 is parked in a holding register, phase 1 is
// merged lane-wise on top of it, and the aligned message is registered towards the
// VNUs behind a valid/ready handshake.
//
// Ports:
//   sys_clk     single rising-edge clock
//   rst         synchronous active-high reset
//   bank_valid  bank beat valid
//   bank_phase  0 = non-shared lanes, 1 = shared lanes
//   bank_rdata  lane i at [i*DATA_W +: DATA_W]
//   bank_ready  beat accepted when bank_valid && bank_ready
//   vnu_valid   merged message valid (registered)
//   vnu_msg     merged message, same lane packing (registered)
//   vnu_ready   VNU consumes when vnu_valid && vnu_ready
//   phase_err   sticky protocol error, cleared only by rst
//   msg_cnt     messages consumed by the VNU, wraps

// Per-lane source select: shared lanes come from the phase-1 beat, the rest from
// the phase-0 source.
module memshare_vnu_lane #(
  parameter int DATA_W = 4,
  parameter bit SHARED = 1'b0
) (
  input  logic [DATA_W-1:0] p0_lane,
  input  logic [DATA_W-1:0] p1_lane,
  output logic [DATA_W-1:0] msg_lane
);
  assign msg_lane = SHARED ? p1_lane : p0_lane;
endmodule

module memshare_vnu_out #(
  parameter int                   GROUP_NUM        = 5,
  parameter logic [GROUP_NUM-1:0] SHARE_COL_CONFIG = 5'b10101,
  parameter int                   DATA_W           = 4,
  parameter int                   CNT_W            = 16
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        bank_valid,
  input  logic                        bank_phase,
  input  logic [GROUP_NUM*DATA_W-1:0] bank_rdata,
  output logic                        bank_ready,
  output logic                        vnu_valid,
  output logic [GROUP_NUM*DATA_W-1:0] vnu_msg,
  input  logic                        vnu_ready,
  output logic                        phase_err,
  output logic [CNT_W-1:0]            msg_cnt
);

  localparam int MSG_W    = GROUP_NUM * DATA_W;
  // With no shared column a single phase-0 beat is already a full message.
  localparam bit NO_SHARE = (SHARE_COL_CONFIG == '0);

  typedef enum logic {EXP_P0, EXP_P1} state_t;

  state_t            state;
  logic [MSG_W-1:0]  hold;
  logic [MSG_W-1:0]  p0_src;
  logic [MSG_W-1:0]  merged;
  logic              out_free;
  logic              accept;

  // In the degenerate config the phase-0 lanes bypass the holding register.
  assign p0_src = NO_SHARE ? bank_rdata : hold;

  for (genvar g = 0; g < GROUP_NUM; g++) begin : g_lane
    memshare_vnu_lane #(
      .DATA_W (DATA_W),
      .SHARED (SHARE_COL_CONFIG[g])
    ) u_lane (
      .p0_lane  (p0_src[g*DATA_W +: DATA_W]),
      .p1_lane  (bank_rdata[g*DATA_W +: DATA_W]),
      .msg_lane (merged[g*DATA_W +: DATA_W])
    );
  end

  // Output register can take a new message if empty or being drained this cycle.
  assign out_free = !vnu_valid || vnu_ready;

  // Capturing phase 0 needs no output space; anything that loads the output does.
  always_comb begin
    bank_ready = 1'b0;
    case (state)
      EXP_P0:  bank_ready = NO_SHARE ? out_free : 1'b1;
      EXP_P1:  bank_ready = out_free;
      default: bank_ready = 1'b0;
    endcase
  end

  assign accept = bank_valid && bank_ready;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= EXP_P0;
      hold      <= '0;
      vnu_valid <= 1'b0;
      vnu_msg   <= '0;
      phase_err <= 1'b0;
      msg_cnt   <= '0;
    end else begin
      // Drain first; a load in the same cycle overrides the clear (no bubble).
      if (vnu_valid && vnu_ready) begin
        msg_cnt   <= msg_cnt + CNT_W'(1);
        vnu_valid <= 1'b0;
      end
      if (accept) begin
        case (state)
          EXP_P0: begin
            if (bank_phase) begin
              // Phase 1 with nothing to merge into: drop it.
              phase_err <= 1'b1;
            end else if (NO_SHARE) begin
              vnu_valid <= 1'b1;
              vnu_msg   <= merged;
            end else begin
              hold  <= bank_rdata;
              state <= EXP_P1;
            end
          end
          EXP_P1: begin
            if (bank_phase) begin
              vnu_valid <= 1'b1;
              vnu_msg   <= merged;
              state     <= EXP_P0;
            end else begin
              // Second phase 0 in a row: restart the message with the new beat.
              hold      <= bank_rdata;
              phase_err <= 1'b1;
            end
          end
          default: state <= EXP_P0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memshare_vnu_out.sv
// Self-checking bench for memshare_vnu_out: directed scenarios with literal
// expectations, then streaming and randomized traffic compared every cycle against
// a transaction-level model (pending phase-0 beat, output slot, error, count).
// A second instance checks the no-share config with a 4-bit counter.
module tb_memshare_vnu_out;

  localparam logic [4:0] CFG = 5'b10101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bank_valid, bank_phase, vnu_ready;
  logic [19:0] bank_rdata;
  logic        bank_ready, vnu_valid, phase_err;
  logic [19:0] vnu_msg;
  logic [15:0] msg_cnt;

  logic        b0_valid, b0_phase, b0_vready;
  logic [19:0] b0_rdata;
  logic        r0, v0, e0;
  logic [19:0] m0;
  logic [3:0]  c0;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  memshare_vnu_out #(.GROUP_NUM(5), .SHARE_COL_CONFIG(CFG), .DATA_W(4), .CNT_W(16)) dut (
    .sys_clk(clk), .rst(rst), .bank_valid(bank_valid), .bank_phase(bank_phase),
    .bank_rdata(bank_rdata), .bank_ready(bank_ready), .vnu_valid(vnu_valid),
    .vnu_msg(vnu_msg), .vnu_ready(vnu_ready), .phase_err(phase_err), .msg_cnt(msg_cnt));

  memshare_vnu_out #(.GROUP_NUM(5), .SHARE_COL_CONFIG(5'b00000), .DATA_W(4), .CNT_W(4)) u0 (
    .sys_clk(clk), .rst(rst), .bank_valid(b0_valid), .bank_phase(b0_phase),
    .bank_rdata(b0_rdata), .bank_ready(r0), .vnu_valid(v0),
    .vnu_msg(m0), .vnu_ready(b0_vready), .phase_err(e0), .msg_cnt(c0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Lane-wise merge: shared lanes from phase 1, the others from phase 0.
  function automatic logic [19:0] merge(input logic [19:0] p0, input logic [19:0] p1);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) r[i*4 +: 4] = CFG[i] ? p1[i*4 +: 4] : p0[i*4 +: 4];
    return r;
  endfunction

  // ---------------- reference model ----------------
  bit          m_pend = 0, m_ov = 0, m_err = 0;
  logic [19:0] m_pd = '0, m_od = '0;
  int unsigned m_cnt = 0;

  always @(posedge clk) begin : model
    bit rdy, acc;
    if (rst) begin
      m_pend = 0; m_pd = '0; m_ov = 0; m_od = '0; m_err = 0; m_cnt = 0;
    end else begin
      rdy = m_pend ? (!m_ov || vnu_ready) : 1'b1;
      acc = bank_valid && rdy;
      if (m_ov && vnu_ready) begin m_cnt++; m_ov = 0; end
      if (acc) begin
        if (!m_pend) begin
          if (bank_phase) m_err = 1;
          else begin m_pend = 1; m_pd = bank_rdata; end
        end else if (bank_phase) begin
          m_ov = 1; m_od = merge(m_pd, bank_rdata); m_pend = 0;
        end else begin
          m_pd = bank_rdata; m_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bank_ready", bank_ready, m_pend ? (!m_ov || vnu_ready) : 1'b1);
      chk("vnu_valid",  vnu_valid,  m_ov);
      chk("vnu_msg",    vnu_msg,    m_od);
      chk("phase_err",  phase_err,  m_err);
      chk("msg_cnt",    msg_cnt,    m_cnt[15:0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit v, input bit ph, input logic [19:0] d, input bit r);
    @(posedge clk); #1;
    bank_valid = v; bank_phase = ph; bank_rdata = d; vnu_ready = r;
    #1;
  endtask

  task automatic step0(input bit v, input logic [19:0] d, input bit r);
    @(posedge clk); #1;
    b0_valid = v; b0_phase = 1'b0; b0_rdata = d; b0_vready = r;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [19:0] d0 [0:16];

  initial begin
    bank_valid = 0; bank_phase = 0; bank_rdata = '0; vnu_ready = 1;
    b0_valid = 0; b0_phase = 0; b0_rdata = '0; b0_vready = 1;

    // Reset state
    do_reset();
    chk("rst_bank_ready", bank_ready, 1);
    chk("rst_vnu_valid", vnu_valid, 0);
    chk("rst_vnu_msg", vnu_msg, 0);
    chk("rst_phase_err", phase_err, 0);
    chk("rst_msg_cnt", msg_cnt, 0);
    chk_en = 1'b1;

    // Basic merge
    step(1, 0, 20'h0A0B0, 1);
    step(1, 1, 20'h5F6F7, 1);
    step(0, 0, '0, 1);
    chk("basic_valid", vnu_valid, 1);
    chk("basic_msg", vnu_msg, 20'h5A6B7);
    step(0, 0, '0, 1);
    chk("basic_valid_drop", vnu_valid, 0);
    chk("basic_cnt", msg_cnt, 1);
    chk("basic_err", phase_err, 0);

    // Back-pressure
    do_reset();
    step(1, 0, 20'h12345, 0);
    step(1, 1, 20'h6789A, 0);
    step(1, 0, 20'hFEDCB, 0);
    chk("bp_msg1", vnu_msg, 20'h6284A);
    chk("bp_valid1", vnu_valid, 1);
    step(1, 1, 20'h01234, 0);
    chk("bp_ready_low", bank_ready, 0);
    step(1, 1, 20'h01234, 0);
    chk("bp_msg1_held", vnu_msg, 20'h6284A);
    chk("bp_ready_low2", bank_ready, 0);
    step(1, 1, 20'h01234, 1);
    chk("bp_ready_free", bank_ready, 1);
    step(0, 0, '0, 1);
    chk("bp_valid2", vnu_valid, 1);
    chk("bp_msg2", vnu_msg, 20'h0E2C4);
    chk("bp_cnt1", msg_cnt, 1);
    step(0, 0, '0, 0);
    chk("bp_cnt2", msg_cnt, 2);
    chk("bp_valid_drop", vnu_valid, 0);

    // Phase errors
    do_reset();
    step(1, 1, 20'hFFFFF, 1);
    step(1, 0, 20'h01020, 1);
    chk("perr_flag", phase_err, 1);
    chk("perr_no_valid", vnu_valid, 0);
    step(1, 0, 20'h0C0D0, 1);
    step(1, 1, 20'h10203, 1);
    step(0, 0, '0, 1);
    chk("perr_msg", vnu_msg, 20'h1C2D3);
    chk("perr_valid", vnu_valid, 1);
    chk("perr_sticky", phase_err, 1);

    // Reset mid-merge
    do_reset();
    step(1, 0, 20'hABCDE, 1);
    step(0, 0, '0, 1);
    rst = 1'b1;
    step(0, 0, '0, 1);
    rst = 1'b0;
    chk("mrst_valid", vnu_valid, 0);
    chk("mrst_msg", vnu_msg, 0);
    chk("mrst_err", phase_err, 0);
    step(1, 1, 20'h55555, 1);
    step(0, 0, '0, 1);
    chk("mrst_p1_err", phase_err, 1);
    chk("mrst_no_valid", vnu_valid, 0);
    step(0, 0, '0, 1);
    chk("mrst_no_valid2", vnu_valid, 0);

    // Streaming, 100 back-to-back pairs
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 20'($urandom), 1);
      step(1, 1, 20'($urandom), 1);
    end
    repeat (3) step(0, 0, '0, 1);
    chk("stream_cnt", msg_cnt, 100);
    chk("stream_err", phase_err, 0);

    // Randomized traffic, mostly well-formed, with back-pressure and rare resets
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 3) != 0, m_pend ^ ($urandom_range(0, 7) == 0),
           20'($urandom), $urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    repeat (3) step(0, 0, '0, 1);

    // No-share config, 4-bit counter: one message per beat, wraps after 16
    do_reset();
    for (int k = 0; k < 17; k++) d0[k] = 20'($urandom);
    for (int k = 0; k < 17; k++) begin
      step0(1, d0[k], 1);
      if (k > 0) begin
        chk("cfg0_valid", v0, 1);
        chk("cfg0_msg", m0, d0[k-1]);
      end
    end
    step0(0, '0, 1);
    chk("cfg0_last_msg", m0, d0[16]);
    step0(0, '0, 1);
    chk("cfg0_cnt_wrap", c0, 1);
    chk("cfg0_valid_drop", v0, 0);
    step0(1, 20'h13579, 0);
    step0(1, 20'h2468A, 0);
    chk("cfg0_bp_msg", m0, 20'h13579);
    chk("cfg0_bp_ready", r0, 0);
    step0(1, 20'h2468A, 0);
    chk("cfg0_bp_held", m0, 20'h13579);
    chk("cfg0_err", e0, 0);
    step0(0, '0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
